// File: rtl/serdesphy_tx_pkg.sv
// Shared definitions for the TX link sequencer: state encoding, default
// link words and the payload source-select encoding.
`timescale 1ns/1ps
package serdesphy_tx_pkg;

    typedef enum logic [2:0] {
        ST_OFF       = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_TRAIN     = 3'd2,
        ST_SYNC      = 3'd3,
        ST_PAYLOAD   = 3'd4,
        ST_IDLE      = 3'd5,
        ST_ERROR     = 3'd6
    } seq_state_t;

    localparam logic [7:0] DEF_TRAIN_WORD = 8'h55;
    localparam logic [7:0] DEF_SYNC_WORD  = 8'hD5;
    localparam logic [7:0] DEF_IDLE_WORD  = 8'h00;

    localparam logic SRC_FIFO = 1'b0;
    localparam logic SRC_PRBS = 1'b1;

    // SYNC, PAYLOAD and IDLE are the states in which the link carries framed traffic.
    function automatic logic state_is_active(input seq_state_t s);
        return (s == ST_SYNC) || (s == ST_PAYLOAD) || (s == ST_IDLE);
    endfunction

endpackage

// File: rtl/serdesphy_tx_link_sequencer.sv
// TX link bring-up sequencer: qualifies PLL lock, sends training and sync words,
// then feeds payload (FIFO or PRBS) or idle fill into a one-word encoder slot.
`timescale 1ns/1ps
module serdesphy_tx_link_sequencer
    import serdesphy_tx_pkg::*;
#(
    parameter int unsigned LOCK_CYCLES = 64,
    parameter int unsigned TRAIN_WORDS = 16,
    parameter logic [7:0]  TRAIN_WORD  = DEF_TRAIN_WORD,
    parameter logic [7:0]  SYNC_WORD   = DEF_SYNC_WORD,
    parameter logic [7:0]  IDLE_WORD   = DEF_IDLE_WORD
) (
    input  logic       clk_24m,
    input  logic       rst_n_24m,
    input  logic       tx_en,
    input  logic       pll_lock,
    input  logic       tx_idle,
    input  logic       tx_data_sel,
    input  logic       fifo_empty,
    input  logic [7:0] fifo_data,
    output logic       fifo_rd_en,
    input  logic [7:0] prbs_data,
    output logic       prbs_adv,
    input  logic       enc_ready,
    output logic [7:0] word_out,
    output logic       word_valid,
    output logic [2:0] seq_state,
    output logic       tx_active,
    output logic       tx_error,
    output logic [7:0] underflow_cnt
);

    localparam int LCW = $clog2(LOCK_CYCLES) + 1;
    localparam logic [LCW-1:0] LOCK_LAST  = LCW'(LOCK_CYCLES - 1);
    localparam logic [7:0]     TRAIN_LAST = 8'(TRAIN_WORDS - 1);

    seq_state_t     state;
    logic [LCW-1:0] lock_cnt;
    logic [7:0]     train_cnt;
    logic           sel_q;
    logic           load;
    logic           payload_pop;

    assign load = !word_valid || enc_ready;

    // A payload load consumes a source word unless idle fill pre-empts it.
    assign payload_pop = tx_en && pll_lock && !tx_idle && load && (state == ST_PAYLOAD);
    assign prbs_adv    = payload_pop && (sel_q == SRC_PRBS);
    assign fifo_rd_en  = payload_pop && (sel_q == SRC_FIFO) && !fifo_empty;

    assign seq_state = state;
    assign tx_active = state_is_active(state);
    assign tx_error  = (state == ST_ERROR);

    always_ff @(posedge clk_24m) begin
        if (!rst_n_24m) begin
            state         <= ST_OFF;
            lock_cnt      <= '0;
            train_cnt     <= '0;
            sel_q         <= SRC_FIFO;
            underflow_cnt <= '0;
            word_out      <= '0;
            word_valid    <= 1'b0;
        end else if (!tx_en) begin
            state         <= ST_OFF;
            lock_cnt      <= '0;
            train_cnt     <= '0;
            underflow_cnt <= '0;
            word_valid    <= 1'b0;
        end else begin
            case (state)
                ST_OFF: begin
                    state         <= ST_WAIT_LOCK;
                    underflow_cnt <= '0;
                    word_valid    <= 1'b0;
                end
                ST_WAIT_LOCK: begin
                    word_valid <= 1'b0;
                    if (!pll_lock) begin
                        lock_cnt <= '0;
                    end else if (lock_cnt == LOCK_LAST) begin
                        lock_cnt  <= '0;
                        train_cnt <= '0;
                        state     <= ST_TRAIN;
                    end else begin
                        lock_cnt <= lock_cnt + LCW'(1);
                    end
                end
                ST_ERROR: begin
                    word_valid <= 1'b0;
                end
                ST_TRAIN, ST_SYNC, ST_PAYLOAD, ST_IDLE: begin
                    // Lock loss wins over any transfer in flight; the held word is dropped.
                    if (!pll_lock) begin
                        state      <= ST_ERROR;
                        word_valid <= 1'b0;
                    end else if (load) begin
                        word_valid <= 1'b1;
                        if (state == ST_TRAIN) begin
                            word_out  <= TRAIN_WORD;
                            train_cnt <= train_cnt + 8'd1;
                            if (train_cnt == TRAIN_LAST) begin
                                state <= ST_SYNC;
                            end
                        end else if (state == ST_SYNC) begin
                            word_out <= SYNC_WORD;
                            sel_q    <= tx_data_sel;
                            state    <= ST_PAYLOAD;
                        end else if (state == ST_PAYLOAD) begin
                            if (tx_idle) begin
                                word_out <= IDLE_WORD;
                                state    <= ST_IDLE;
                            end else if (sel_q == SRC_PRBS) begin
                                word_out <= prbs_data;
                            end else if (!fifo_empty) begin
                                word_out <= fifo_data;
                            end else begin
                                word_out <= IDLE_WORD;
                                if (underflow_cnt != 8'hFF) begin
                                    underflow_cnt <= underflow_cnt + 8'd1;
                                end
                            end
                        end else begin
                            // Leaving idle re-syncs the receiver and re-samples the source.
                            if (tx_idle) begin
                                word_out <= IDLE_WORD;
                            end else begin
                                word_out <= SYNC_WORD;
                                sel_q    <= tx_data_sel;
                                state    <= ST_PAYLOAD;
                            end
                        end
                    end
                end
                default: begin
                    state      <= ST_OFF;
                    word_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serdesphy_tx_link_sequencer.sv
// Self-checking bench for the TX link sequencer: a scoreboard of expected encoder
// words plus FIFO/PRBS source models, with one task per scenario.
`timescale 1ns/1ps
module tb_serdesphy_tx_link_sequencer;

    localparam int LOCK_CYCLES = 8;
    localparam int TRAIN_WORDS = 4;

    logic       clk_24m = 1'b0;
    logic       rst_n_24m = 1'b0;
    logic       tx_en = 1'b0;
    logic       pll_lock = 1'b0;
    logic       tx_idle = 1'b0;
    logic       tx_data_sel = 1'b0;
    logic       fifo_empty = 1'b1;
    logic [7:0] fifo_data = 8'h00;
    logic       fifo_rd_en;
    logic [7:0] prbs_data = 8'hA7;
    logic       prbs_adv;
    logic       enc_ready = 1'b0;
    logic [7:0] word_out;
    logic       word_valid;
    logic [2:0] seq_state;
    logic       tx_active;
    logic       tx_error;
    logic [7:0] underflow_cnt;

    int         total = 0;
    int         bad = 0;
    logic [7:0] exp_q[$];
    logic [7:0] fifo_q[$];
    bit         sb_on = 1'b0;
    bit         pop_req = 1'b0;
    bit         adv_req = 1'b0;
    int         rd_count = 0;
    int         adv_count = 0;

    always #21 clk_24m = ~clk_24m;

    serdesphy_tx_link_sequencer #(
        .LOCK_CYCLES(LOCK_CYCLES),
        .TRAIN_WORDS(TRAIN_WORDS)
    ) dut (
        .clk_24m(clk_24m),
        .rst_n_24m(rst_n_24m),
        .tx_en(tx_en),
        .pll_lock(pll_lock),
        .tx_idle(tx_idle),
        .tx_data_sel(tx_data_sel),
        .fifo_empty(fifo_empty),
        .fifo_data(fifo_data),
        .fifo_rd_en(fifo_rd_en),
        .prbs_data(prbs_data),
        .prbs_adv(prbs_adv),
        .enc_ready(enc_ready),
        .word_out(word_out),
        .word_valid(word_valid),
        .seq_state(seq_state),
        .tx_active(tx_active),
        .tx_error(tx_error),
        .underflow_cnt(underflow_cnt)
    );

    function automatic logic [7:0] prbs_step(input logic [7:0] p);
        return {p[6:0], p[7] ^ p[5] ^ p[4] ^ p[3]};
    endfunction

    // Strobes and transfers are sampled mid-cycle, where they are stable for the next edge.
    always @(negedge clk_24m) begin
        logic [7:0] exp_w;
        pop_req = fifo_rd_en;
        adv_req = prbs_adv;
        if (fifo_rd_en) rd_count++;
        if (prbs_adv) adv_count++;
        if (sb_on && word_valid && enc_ready) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("[TB] FAIL unexpected_word: got %02h, none expected", word_out);
            end else begin
                exp_w = exp_q.pop_front();
                if (word_out !== exp_w) begin
                    bad++;
                    $display("[TB] FAIL word_out: got %02h, expected %02h", word_out, exp_w);
                end
            end
        end
    end

    // First-word-fall-through FIFO and PRBS source models, updated after the edge.
    always @(posedge clk_24m) begin
        #2;
        if (pop_req && fifo_q.size() > 0) void'(fifo_q.pop_front());
        if (adv_req) prbs_data = prbs_step(prbs_data);
        fifo_empty = (fifo_q.size() == 0);
        if (fifo_empty) fifo_data = 8'h00;
        else fifo_data = fifo_q[0];
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk_24m);
        #1;
    endtask

    task automatic wait_state(input logic [2:0] target, input int budget, output bit ok);
        int n = 0;
        while (seq_state !== target && n < budget) begin
            @(posedge clk_24m);
            #1;
            n++;
        end
        ok = (seq_state === target);
    endtask

    task automatic drain(input int budget, output int used);
        used = 0;
        while (exp_q.size() != 0 && used < budget) begin
            @(posedge clk_24m);
            #1;
            used++;
        end
    endtask

    task automatic do_reset();
        sb_on = 1'b0;
        rst_n_24m = 1'b0;
        tx_en = 1'b0;
        pll_lock = 1'b0;
        tx_idle = 1'b0;
        tx_data_sel = 1'b0;
        enc_ready = 1'b0;
        exp_q.delete();
        fifo_q.delete();
        wait_cycles(3);
        rst_n_24m = 1'b1;
        rd_count = 0;
        adv_count = 0;
    endtask

    task automatic start_link(input logic sel);
        tx_data_sel = sel;
        tx_idle = 1'b0;
        tx_en = 1'b1;
        pll_lock = 1'b1;
        enc_ready = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        total++;
        if (seq_state !== 3'd0) begin bad++; $display("[TB] FAIL reset_state: got %0d, expected 0", seq_state); end
        total++;
        if ({word_valid, word_out} !== 9'h000) begin bad++; $display("[TB] FAIL reset_slot: got valid=%0b word=%02h, expected 0/00", word_valid, word_out); end
        total++;
        if ({tx_active, tx_error, fifo_rd_en, prbs_adv} !== 4'b0000) begin bad++; $display("[TB] FAIL reset_flags: got %04b, expected 0000", {tx_active, tx_error, fifo_rd_en, prbs_adv}); end
        total++;
        if (underflow_cnt !== 8'd0) begin bad++; $display("[TB] FAIL reset_underflow: got %0d, expected 0", underflow_cnt); end
        pll_lock = 1'b1;
        wait_cycles(2);
        total++;
        if (seq_state !== 3'd0) begin bad++; $display("[TB] FAIL off_without_en: got %0d, expected 0", seq_state); end
        start_link(1'b0);
        wait_cycles(LOCK_CYCLES + 4);
        rst_n_24m = 1'b0;
        wait_cycles(1);
        rst_n_24m = 1'b1;
        total++;
        if ({seq_state, word_valid} !== 4'b0000) begin bad++; $display("[TB] FAIL reset_midrun: got state=%0d valid=%0b, expected 0/0", seq_state, word_valid); end
    endtask

    task automatic test_bring_up();
        int used;
        do_reset();
        fifo_q.push_back(8'h11);
        fifo_q.push_back(8'h22);
        repeat (TRAIN_WORDS) exp_q.push_back(8'h55);
        exp_q.push_back(8'hD5);
        exp_q.push_back(8'h11);
        exp_q.push_back(8'h22);
        repeat (3) exp_q.push_back(8'h00);
        sb_on = 1'b1;
        start_link(1'b0);
        wait_cycles(1);
        total++;
        if (seq_state !== 3'd1) begin bad++; $display("[TB] FAIL bringup_wait_lock: got %0d, expected 1", seq_state); end
        wait_cycles(LOCK_CYCLES - 1);
        total++;
        if (seq_state !== 3'd1) begin bad++; $display("[TB] FAIL bringup_lock_early: got %0d, expected 1", seq_state); end
        wait_cycles(1);
        total++;
        if (seq_state !== 3'd2) begin bad++; $display("[TB] FAIL bringup_train: got %0d, expected 2", seq_state); end
        drain(40, used);
        total++;
        if (exp_q.size() != 0) begin bad++; $display("[TB] FAIL bringup_drain: %0d words outstanding, expected 0", exp_q.size()); end
        total++;
        if (used != 11) begin bad++; $display("[TB] FAIL bringup_throughput: took %0d cycles, expected 11", used); end
        enc_ready = 1'b0;
        wait_cycles(1);
        total++;
        if (underflow_cnt !== 8'd4) begin bad++; $display("[TB] FAIL bringup_underflow: got %0d, expected 4", underflow_cnt); end
        total++;
        if (rd_count != 2) begin bad++; $display("[TB] FAIL bringup_pops: got %0d, expected 2", rd_count); end
        total++;
        if (tx_active !== 1'b1) begin bad++; $display("[TB] FAIL bringup_active: got %0b, expected 1", tx_active); end
        sb_on = 1'b0;
    endtask

    task automatic test_backpressure();
        bit ok;
        int used;
        do_reset();
        repeat (TRAIN_WORDS) exp_q.push_back(8'h55);
        exp_q.push_back(8'hD5);
        sb_on = 1'b1;
        start_link(1'b0);
        wait_state(3'd2, 30, ok);
        total++;
        if (!ok) begin bad++; $display("[TB] FAIL bp_train_entry: got %0d, expected 2", seq_state); end
        wait_cycles(1);
        enc_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            wait_cycles(1);
            total++;
            if ({word_valid, word_out} !== 9'h155) begin bad++; $display("[TB] FAIL bp_hold: got valid=%0b word=%02h, expected 1/55", word_valid, word_out); end
            total++;
            if (seq_state !== 3'd2) begin bad++; $display("[TB] FAIL bp_state: got %0d, expected 2", seq_state); end
        end
        enc_ready = 1'b1;
        drain(20, used);
        enc_ready = 1'b0;
        total++;
        if (exp_q.size() != 0) begin bad++; $display("[TB] FAIL bp_drain: %0d words outstanding, expected 0", exp_q.size()); end
        wait_cycles(1);
        sb_on = 1'b0;
    endtask

    task automatic test_lock_glitch();
        do_reset();
        start_link(1'b0);
        wait_cycles(LOCK_CYCLES - 2);
        pll_lock = 1'b0;
        wait_cycles(1);
        total++;
        if (seq_state !== 3'd1) begin bad++; $display("[TB] FAIL glitch_wait: got %0d, expected 1", seq_state); end
        pll_lock = 1'b1;
        wait_cycles(LOCK_CYCLES - 1);
        total++;
        if (seq_state !== 3'd1) begin bad++; $display("[TB] FAIL glitch_early_train: got %0d, expected 1", seq_state); end
        wait_cycles(1);
        total++;
        if (seq_state !== 3'd2) begin bad++; $display("[TB] FAIL glitch_train: got %0d, expected 2", seq_state); end
    endtask

    task automatic test_lock_loss();
        bit ok;
        do_reset();
        start_link(1'b0);
        wait_state(3'd4, 40, ok);
        total++;
        if (!ok) begin bad++; $display("[TB] FAIL loss_payload_entry: got %0d, expected 4", seq_state); end
        wait_cycles(2);
        total++;
        if (underflow_cnt !== 8'd2) begin bad++; $display("[TB] FAIL loss_underflow: got %0d, expected 2", underflow_cnt); end
        pll_lock = 1'b0;
        wait_cycles(1);
        total++;
        if ({seq_state, tx_error, word_valid, tx_active} !== 6'b110_1_0_0) begin
            bad++;
            $display("[TB] FAIL loss_error: got state=%0d err=%0b valid=%0b active=%0b, expected 6/1/0/0", seq_state, tx_error, word_valid, tx_active);
        end
        pll_lock = 1'b1;
        wait_cycles(2);
        total++;
        if (seq_state !== 3'd6 || underflow_cnt !== 8'd2) begin bad++; $display("[TB] FAIL loss_sticky: got state=%0d uf=%0d, expected 6/2", seq_state, underflow_cnt); end
        tx_en = 1'b0;
        wait_cycles(1);
        total++;
        if ({seq_state, tx_error, word_valid} !== 5'b000_0_0) begin bad++; $display("[TB] FAIL loss_off: got state=%0d err=%0b valid=%0b, expected 0/0/0", seq_state, tx_error, word_valid); end
        total++;
        if (underflow_cnt !== 8'd0) begin bad++; $display("[TB] FAIL loss_uf_clear: got %0d, expected 0", underflow_cnt); end
    endtask

    task automatic test_idle_prbs();
        bit ok;
        int used;
        logic [7:0] p;
        do_reset();
        start_link(1'b1);
        wait_cycles(1);
        p = prbs_data;
        repeat (TRAIN_WORDS) exp_q.push_back(8'h55);
        exp_q.push_back(8'hD5);
        for (int i = 0; i < 3; i++) begin exp_q.push_back(p); p = prbs_step(p); end
        repeat (3) exp_q.push_back(8'h00);
        exp_q.push_back(8'hD5);
        for (int i = 0; i < 2; i++) begin exp_q.push_back(p); p = prbs_step(p); end
        sb_on = 1'b1;
        wait_state(3'd4, 40, ok);
        total++;
        if (!ok) begin bad++; $display("[TB] FAIL idle_payload_entry: got %0d, expected 4", seq_state); end
        wait_cycles(3);
        tx_idle = 1'b1;
        for (int i = 0; i < 3; i++) begin
            wait_cycles(1);
            total++;
            if (seq_state !== 3'd5 || prbs_adv !== 1'b0) begin bad++; $display("[TB] FAIL idle_state: got state=%0d adv=%0b, expected 5/0", seq_state, prbs_adv); end
        end
        tx_idle = 1'b0;
        drain(30, used);
        enc_ready = 1'b0;
        total++;
        if (exp_q.size() != 0) begin bad++; $display("[TB] FAIL idle_drain: %0d words outstanding, expected 0", exp_q.size()); end
        total++;
        if (adv_count != 6) begin bad++; $display("[TB] FAIL idle_adv_count: got %0d, expected 6", adv_count); end
        wait_cycles(1);
        sb_on = 1'b0;
    endtask

    task automatic test_source_select();
        bit ok;
        int used;
        logic [7:0] p;
        do_reset();
        for (int i = 1; i <= 6; i++) fifo_q.push_back(8'hA0 + 8'(i));
        start_link(1'b0);
        wait_cycles(1);
        p = prbs_data;
        repeat (TRAIN_WORDS) exp_q.push_back(8'h55);
        exp_q.push_back(8'hD5);
        for (int i = 1; i <= 4; i++) exp_q.push_back(8'hA0 + 8'(i));
        exp_q.push_back(8'h00);
        exp_q.push_back(8'hD5);
        exp_q.push_back(p);
        exp_q.push_back(prbs_step(p));
        sb_on = 1'b1;
        wait_state(3'd4, 40, ok);
        total++;
        if (!ok) begin bad++; $display("[TB] FAIL sel_payload_entry: got %0d, expected 4", seq_state); end
        wait_cycles(2);
        tx_data_sel = 1'b1;
        wait_cycles(2);
        tx_idle = 1'b1;
        wait_cycles(1);
        tx_idle = 1'b0;
        drain(30, used);
        enc_ready = 1'b0;
        total++;
        if (exp_q.size() != 0) begin bad++; $display("[TB] FAIL sel_drain: %0d words outstanding, expected 0", exp_q.size()); end
        total++;
        if (rd_count != 4 || fifo_q.size() != 2) begin bad++; $display("[TB] FAIL sel_pops: got pops=%0d left=%0d, expected 4/2", rd_count, fifo_q.size()); end
        total++;
        if (adv_count != 3) begin bad++; $display("[TB] FAIL sel_adv_count: got %0d, expected 3", adv_count); end
        wait_cycles(1);
        sb_on = 1'b0;
    endtask

    initial begin
        test_reset();
        test_bring_up();
        test_backpressure();
        test_lock_glitch();
        test_lock_loss();
        test_idle_prbs();
        test_source_select();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
